// File: rtl/alu_pkg.sv
// ============================================================================
// Module : alu_pkg
// Brief  : Shared ALU opcodes, default width and arbiter slot-state type.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam int ALU_W = 16;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_NOR = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL0 = 2'd1,
    FULL1 = 2'd2
  } slot_state_t;

endpackage

`default_nettype wire

// File: rtl/alu_core.sv
// ============================================================================
// Module : alu_core
// Brief  : Purely combinational unsigned ALU with zero and overflow/borrow.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W,
  parameter int OPW   = 3
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OPW-1:0]   op,
  output logic [WIDTH-1:0] r,
  output logic             zero,
  output logic             ovfl
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum  = {1'b0, a} + {1'b0, b};
    r    = '0;
    ovfl = 1'b0;
    case (op)
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_NOR: r = ~(a | b);
      OP_ADD: begin
        r    = sum[WIDTH-1:0];
        ovfl = sum[WIDTH];
      end
      OP_SUB: begin
        r    = a - b;
        ovfl = (a < b);
      end
      OP_SLT: r = {{(WIDTH-1){1'b0}}, (a < b)};
      default: r = '0;  // reserved opcodes yield zero
    endcase
    zero = (r == '0);
  end

endmodule

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ============================================================================
// Module : alu_arbiter
// Brief  : Round-robin sharing of one ALU between two requesters with a
//          one-deep registered response slot. Optional grant counters are
//          built when ALU_ARB_CNT_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic             req1_ready,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_r,
  output logic             rsp_zero,
  output logic             rsp_ovfl
`ifdef ALU_ARB_CNT_EN
  ,
  output logic [15:0]      grant_cnt0,
  output logic [15:0]      grant_cnt1
`endif
);

  slot_state_t      state, state_nxt;
  logic             last_grant;
  logic             slot_free;
  logic             grant0, grant1;
  logic [WIDTH-1:0] alu_a, alu_b, alu_r;
  logic [OPW-1:0]   alu_op;
  logic             alu_zero, alu_ovfl;

  // Slot frees when empty or when the holder drains it this cycle; rst_n
  // gating keeps both readies low while reset is asserted.
  always_comb begin
    slot_free = rst_n && ((state == EMPTY) ||
                          ((state == FULL0) && rsp0_ready) ||
                          ((state == FULL1) && rsp1_ready));
    grant0    = slot_free && req0_valid && (!req1_valid || last_grant);
    grant1    = slot_free && req1_valid && (!req0_valid || !last_grant);
    state_nxt = state;
    if (grant0)         state_nxt = FULL0;
    else if (grant1)    state_nxt = FULL1;
    else if (slot_free) state_nxt = EMPTY;
  end

  assign alu_a  = grant1 ? req1_a  : req0_a;
  assign alu_b  = grant1 ? req1_b  : req0_b;
  assign alu_op = grant1 ? req1_op : req0_op;

  alu_core #(
    .WIDTH (WIDTH),
    .OPW   (OPW)
  ) u_alu_core (
    .a    (alu_a),
    .b    (alu_b),
    .op   (alu_op),
    .r    (alu_r),
    .zero (alu_zero),
    .ovfl (alu_ovfl)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      last_grant <= 1'b1;
      rsp_r      <= '0;
      rsp_zero   <= 1'b0;
      rsp_ovfl   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant0 || grant1) begin
        last_grant <= grant1;
        rsp_r      <= alu_r;
        rsp_zero   <= alu_zero;
        rsp_ovfl   <= alu_ovfl;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rsp0_valid = (state == FULL0);
  assign rsp1_valid = (state == FULL1);

`ifdef ALU_ARB_CNT_EN
  logic [15:0] cnt0, cnt1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (grant0 && (cnt0 != 16'hFFFF)) cnt0 <= cnt0 + 16'd1;
      if (grant1 && (cnt1 != 16'hFFFF)) cnt1 <= cnt1 + 16'd1;
    end
  end

  assign grant_cnt0 = cnt0;
  assign grant_cnt1 = cnt1;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// Module : tb_alu_arbiter
// Brief  : Self-checking bench for alu_arbiter against a behavioural model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_arbiter;

  logic        clk, rst_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_op, req1_op;
  logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [15:0] rsp_r;
  logic        rsp_zero, rsp_ovfl;
`ifdef ALU_ARB_CNT_EN
  logic [15:0] grant_cnt0, grant_cnt1;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model state: owner -1 = empty slot.
  int          m_owner;
  bit          m_last;
  logic [15:0] m_r;
  bit          m_z, m_o;
  int          m_cnt0, m_cnt1;

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_r(rsp_r), .rsp_zero(rsp_zero), .rsp_ovfl(rsp_ovfl)
`ifdef ALU_ARB_CNT_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [19:0] dut_rsp = {rsp0_valid, rsp1_valid, rsp_r, rsp_zero, rsp_ovfl};
  wire [1:0]  dut_rdy = {req1_ready, req0_ready};

  function automatic void alu_ref(input int unsigned a, input int unsigned b, input int op,
                                  output logic [15:0] r, output bit z, output bit o);
    int unsigned res;
    o = 1'b0;
    case (op)
      0: res = a & b;
      1: res = a | b;
      2: res = 32'hFFFF - (a | b);
      3: begin res = (a + b) % 65536; o = (a + b) > 65535; end
      4: begin res = (a + 65536 - b) % 65536; o = a < b; end
      5: res = (a < b) ? 1 : 0;
      default: res = 0;
    endcase
    r = res[15:0];
    z = (res == 0);
  endfunction

  function automatic bit slot_free();
    if (rst_n !== 1'b1) return 1'b0;
    return (m_owner == -1) || (m_owner == 0 && rsp0_ready) || (m_owner == 1 && rsp1_ready);
  endfunction

  function automatic int exp_grant();
    if (!slot_free()) return -1;
    if (req0_valid && req1_valid) return m_last ? 0 : 1;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  function automatic logic [1:0] exp_ready();
    int g = exp_grant();
    return (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [19:0] exp_rsp();
    return {m_owner == 0, m_owner == 1, m_r, m_z, m_o};
  endfunction

  task automatic model_reset();
    m_owner = -1; m_last = 1'b1; m_r = '0; m_z = 1'b0; m_o = 1'b0;
    m_cnt0 = 0; m_cnt1 = 0;
  endtask

  // Advance one clock edge and move the model along with it.
  task automatic tick();
    int g  = exp_grant();
    bit fr = slot_free();
    @(posedge clk);
    if (g == 0) begin
      alu_ref(req0_a, req0_b, req0_op, m_r, m_z, m_o);
      if (m_cnt0 < 65535) m_cnt0++;
    end else if (g == 1) begin
      alu_ref(req1_a, req1_b, req1_op, m_r, m_z, m_o);
      if (m_cnt1 < 65535) m_cnt1++;
    end
    if (g >= 0) begin
      m_owner = g;
      m_last  = (g == 1);
    end else if (fr) begin
      m_owner = -1;
    end
    #1;
  endtask

  task automatic idle();
    req0_valid = 0; req1_valid = 0;
    req0_a = 0; req0_b = 0; req0_op = 0;
    req1_a = 0; req1_b = 0; req1_op = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [19:0] zero_rsp = '0;
    rst_n = 1'b0; idle(); rsp0_ready = 1; rsp1_ready = 1;
    model_reset();
    req0_valid = 1; req1_valid = 1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (dut_rsp !== zero_rsp) begin
      failures++; $display("FAIL reset_state: got %h expected %h", dut_rsp, zero_rsp);
    end
    checks++;
    if (dut_rdy !== 2'b00) begin
      failures++; $display("FAIL reset_ready: got %b expected 00", dut_rdy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (dut_rdy !== 2'b01) begin
      failures++; $display("FAIL reset_first_grant: got %b expected 01", dut_rdy);
    end
    idle();
  endtask

  task automatic test_reset_mid();
    logic [19:0] want = {1'b1, 1'b0, 16'h0007, 1'b0, 1'b0};
    logic [19:0] zero_rsp = '0;
    @(negedge clk);
    rsp0_ready = 0; rsp1_ready = 0;
    req0_valid = 1; req0_a = 16'd3; req0_b = 16'd4; req0_op = 3'b011;
    tick();
    checks++;
    if (dut_rsp !== want) begin
      failures++; $display("FAIL mid_add_held: got %h expected %h", dut_rsp, want);
    end
    idle();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut_rsp !== zero_rsp) begin
      failures++; $display("FAIL mid_reset_discard: got %h expected %h", dut_rsp, zero_rsp);
    end
    @(negedge clk);
    rst_n = 1'b1;
    rsp0_ready = 1; rsp1_ready = 1;
    req0_valid = 1; req1_valid = 1;
    req0_op = 3'b001; req0_a = 16'h00A0; req1_op = 3'b000;
    #1;
    checks++;
    if (dut_rdy !== 2'b01) begin
      failures++; $display("FAIL mid_first_grant: got %b expected 01", dut_rdy);
    end
    tick();
    checks++;
    if (dut_rsp !== exp_rsp()) begin
      failures++; $display("FAIL mid_first_rsp: got %h expected %h", dut_rsp, exp_rsp());
    end
    idle();
  endtask

  task automatic test_contention();
    logic [19:0] want;
    do_reset();
    rsp0_ready = 1; rsp1_ready = 1;
    req0_valid = 1; req0_a = 16'hF0F0; req0_b = 16'h0FF0; req0_op = 3'b000;
    req1_valid = 1; req1_a = 16'h00FF; req1_b = 16'hFF00; req1_op = 3'b001;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (dut_rdy !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        failures++; $display("FAIL contention_grant[%0d]: got %b", i, dut_rdy);
      end
      tick();
      want = (i % 2 == 0) ? {2'b10, 16'h00F0, 2'b00} : {2'b01, 16'hFFFF, 2'b00};
      checks++;
      if (dut_rsp !== want) begin
        failures++; $display("FAIL contention_rsp[%0d]: got %h expected %h", i, dut_rsp, want);
      end
      @(negedge clk);
    end
    idle();
  endtask

  task automatic test_flags();
    logic [15:0] ta [3] = '{16'hFFFF, 16'h0002, 16'd5};
    logic [15:0] tb [3] = '{16'h0001, 16'h0005, 16'd9};
    logic [2:0]  to [3] = '{3'b011, 3'b100, 3'b101};
    logic [19:0] tw [3] = '{{2'b10, 16'h0000, 2'b11},
                           {2'b10, 16'hFFFD, 2'b01},
                           {2'b10, 16'h0001, 2'b00}};
    rsp0_ready = 1; rsp1_ready = 1;
    for (int i = 0; i < 3; i++) begin
      req0_valid = 1; req0_a = ta[i]; req0_b = tb[i]; req0_op = to[i];
      tick();
      checks++;
      if (dut_rsp !== tw[i]) begin
        failures++; $display("FAIL flags[%0d]: got %h expected %h", i, dut_rsp, tw[i]);
      end
      @(negedge clk);
    end
    idle();
  endtask

  task automatic test_backpressure();
    logic [19:0] held = {2'b01, 16'h3333, 2'b00};
    logic [19:0] want = {2'b10, 16'h0F00, 2'b00};
    rsp1_ready = 0; rsp0_ready = 1;
    req1_valid = 1; req1_a = 16'h1111; req1_b = 16'h2222; req1_op = 3'b011;
    tick();
    @(negedge clk);
    idle();
    req0_valid = 1; req0_a = 16'hFF00; req0_b = 16'h0FF0; req0_op = 3'b000;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (dut_rdy !== 2'b00) begin
        failures++; $display("FAIL bp_ready[%0d]: got %b expected 00", i, dut_rdy);
      end
      tick();
      checks++;
      if (dut_rsp !== held) begin
        failures++; $display("FAIL bp_hold[%0d]: got %h expected %h", i, dut_rsp, held);
      end
      @(negedge clk);
    end
    rsp1_ready = 1;
    #1;
    checks++;
    if (dut_rdy !== 2'b01) begin
      failures++; $display("FAIL bp_refill_ready: got %b expected 01", dut_rdy);
    end
    tick();
    checks++;
    if (dut_rsp !== want) begin
      failures++; $display("FAIL bp_refill_rsp: got %h expected %h", dut_rsp, want);
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_reserved();
    logic [19:0] want = {2'b10, 16'h0000, 2'b10};
    rsp0_ready = 1; rsp1_ready = 1;
    for (int i = 6; i < 8; i++) begin
      req0_valid = 1; req0_a = 16'h1234; req0_b = 16'($urandom); req0_op = 3'(i);
      tick();
      checks++;
      if (dut_rsp !== want) begin
        failures++; $display("FAIL reserved[%0d]: got %h expected %h", i, dut_rsp, want);
      end
      @(negedge clk);
    end
    idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      req0_valid = ($urandom_range(0, 9) < 7);
      req1_valid = ($urandom_range(0, 9) < 7);
      req0_a = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      req0_b = 16'($urandom);
      req1_a = 16'($urandom);
      req1_b = ($urandom_range(0, 3) == 0) ? req1_a : 16'($urandom);
      req0_op = 3'($urandom_range(0, 7));
      req1_op = 3'($urandom_range(0, 7));
      rsp0_ready = ($urandom_range(0, 9) < 6);
      rsp1_ready = ($urandom_range(0, 9) < 6);
      #1;
      checks++;
      if (dut_rdy !== exp_ready()) begin
        failures++; $display("FAIL rand_ready[%0d]: got %b expected %b", i, dut_rdy, exp_ready());
      end
      tick();
      checks++;
      if (dut_rsp !== exp_rsp()) begin
        failures++; $display("FAIL rand_rsp[%0d]: got %h expected %h", i, dut_rsp, exp_rsp());
      end
`ifdef ALU_ARB_CNT_EN
      checks++;
      if (grant_cnt0 !== 16'(m_cnt0) || grant_cnt1 !== 16'(m_cnt1)) begin
        failures++; $display("FAIL rand_cnt[%0d]: got %h/%h expected %h/%h", i,
                             grant_cnt0, grant_cnt1, 16'(m_cnt0), 16'(m_cnt1));
      end
`endif
      @(negedge clk);
    end
    idle();
  endtask

`ifdef ALU_ARB_CNT_EN
  task automatic test_counters();
    do_reset();
    force dut.cnt0 = 16'hFFFE;
    #1 release dut.cnt0;
    m_cnt0 = 65534;
    rsp0_ready = 1; rsp1_ready = 1;
    req0_valid = 1; req0_op = 3'b001;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (grant_cnt0 !== 16'hFFFF) begin
        failures++; $display("FAIL cnt_sat[%0d]: got %h expected ffff", i, grant_cnt0);
      end
      @(negedge clk);
    end
    checks++;
    if (grant_cnt1 !== 16'h0000) begin
      failures++; $display("FAIL cnt1_idle: got %h expected 0000", grant_cnt1);
    end
    idle();
  endtask
`endif

  initial begin
    test_reset();
    test_reset_mid();
    test_contention();
    test_flags();
    test_backpressure();
    test_reserved();
    test_random();
`ifdef ALU_ARB_CNT_EN
    test_counters();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one 16-bit ALU datapath between two requesters: requester 0 is the fetch/branch unit, requester 1 is the execute unit.
- Round-robin arbitration picks one operation per cycle.
- The ALU result is registered into a one-deep output stage and returned to the granted requester with a valid/ready handshake.
- Sits between the pipeline control logic and the shared ALU; it is the only block that drives the ALU operands.

Parameters:
- WIDTH, 16, operand/result width.
- OPW, 3, opcode width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_a  in  WIDTH  requester 0 operand A.
- req0_b  in  WIDTH  requester 0 operand B.
- req0_op  in  OPW  requester 0 opcode.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req1_valid / req1_a / req1_b / req1_op / req1_ready  same as requester 0, for requester 1.
- rsp0_valid  out  1  result for requester 0 is held.
- rsp0_ready  in  1  requester 0 consumes its result.
- rsp1_valid  out  1  result for requester 1 is held.
- rsp1_ready  in  1  requester 1 consumes its result.
- rsp_r  out  WIDTH  registered result, shared by both requesters.
- rsp_zero  out  1  registered zero flag (rsp_r == 0).
- rsp_ovfl  out  1  registered overflow/borrow flag.

Behaviour:
- Reset (async, rst_n low): rsp0_valid=0, rsp1_valid=0, rsp_r=0, rsp_zero=0, rsp_ovfl=0, last_grant=1 (requester 0 wins first).
  - req*_ready are combinational and therefore 0 during reset.
  - An in-flight result is discarded; no partial response ever appears.
- States:
  - EMPTY: no rsp*_valid asserted.
  - FULL0: rsp0_valid=1.
  - FULL1: rsp1_valid=1.
  - At most one rsp*_valid is high at any time.
- Slot free: state EMPTY, or FULL_k with rspk_ready=1 in the same cycle. Drain and refill in one cycle is allowed, so back-to-back throughput is 1 op/cycle.
- Grant, combinational, only when the slot is free:
  - Both valid: grant the requester != last_grant.
  - One valid: grant that requester.
  - reqk_ready = grant_k.
  - At most one ready is high per cycle.
- On a grant at edge N:
  - The ALU computes from the granted operands.
  - rsp_r and flags are registered at edge N; rspk_valid=1 from N+1.
  - last_grant <= k.
  - Latency is 1 cycle.
- No grant and rspk_ready=1: state goes to EMPTY, and rsp_r/flags hold their last value.
- rsp_r/flags are stable while rspk_valid=1 and rspk_ready=0. Backpressure stalls both requesters.
- rsp_ready for the requester not currently holding the slot is ignored.
- Ops and overflow rules (all unsigned, modulo 2^WIDTH):
  - 000 AND, ovfl=0.
  - 001 OR, ovfl=0.
  - 010 NOR, ovfl=0.
  - 011 ADD, ovfl = carry out of bit WIDTH-1.
  - 100 SUB (a-b), ovfl = (a<b) borrow.
  - 101 SLT unsigned, result = {0...,a<b}, ovfl=0.
  - 110/111 reserved: result=0, zero=1, ovfl=0.
- zero = (result == 0), computed on the full WIDTH result.
- req*_valid may drop without being granted; the arbiter does not latch requests.

Optional Feature:
- Macro ALU_ARB_CNT_EN.
- Defined:
  - Adds out ports grant_cnt0 and grant_cnt1, each 16 bits.
  - Each counter increments on its requester's grant and saturates at 16'hFFFF (no wrap).
  - Counters reset to 0 on rst_n.
  - Simultaneous grant and saturation: the counter holds 16'hFFFF.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package alu_pkg holds:
  - The opcode constants OP_AND=3'b000, OP_OR, OP_NOR, OP_ADD, OP_SUB, OP_SLT.
  - ALU_W=16.
  - A slot-state typedef {EMPTY, FULL0, FULL1}.
- Sub-module alu_core: a purely combinational ALU (a, b, op -> r, zero, ovfl) implementing the rules above. It is instantiated once inside alu_arbiter, and reused by later multi-cycle sequencers.

Test Plan:
- Reset mid-result: req0 ADD 3+4 granted, rst_n pulsed low before rsp0_ready -> rsp0_valid=0 immediately; after release, the first simultaneous request goes to requester 0.
- Contention: both valid for 4 cycles with rsp ready held 1 -> grants alternate 0,1,0,1.
  - req0 AND 16'hF0F0&16'h0FF0 -> rsp_r=16'h00F0.
  - req1 OR 16'h00FF|16'hFF00 -> 16'hFFFF.
- Flags:
  - ADD 16'hFFFF+16'h0001 -> rsp_r=0, zero=1, ovfl=1.
  - SUB 16'h0002-16'h0005 -> rsp_r=16'hFFFD, ovfl=1.
  - SLT 5,9 -> rsp_r=1, ovfl=0.
- Backpressure: rsp1_ready=0 for 3 cycles while req0_valid=1 -> req0_ready=0 and rsp_r stable; with rsp1_ready=1 the same cycle grants req0 (drain + refill).
- Reserved op 3'b111 with a=16'h1234 -> rsp_r=0, zero=1, ovfl=0.
- ALU_ARB_CNT_EN: force grant_cnt0 to 16'hFFFE, issue 3 req0 grants -> the count reaches 16'hFFFF and holds.
